// File: rtl/sram_model_pkg.sv
// Shared definitions for the single-port SRAM behavioural models.
//   state_e     : controller state (clear sequence, then normal operation)
//   LFSR_W/MASK : garbage-generator width and Galois feedback mask
//   lane_merge  : per-bit merge of old and new word data
package sram_model_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int              LFSR_W    = 32;
  // x^32 + x^22 + x^2 + x + 1
  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;

  // Widest word the merge helper supports; callers zero-extend into it
  // and truncate the result back to their own width.
  localparam int MERGE_MAX_W = 1024;

  // bit_we[k]=1 takes new_data[k], otherwise old_data[k] is kept.
  function automatic logic [MERGE_MAX_W-1:0] lane_merge(
    input logic [MERGE_MAX_W-1:0] old_data,
    input logic [MERGE_MAX_W-1:0] new_data,
    input logic [MERGE_MAX_W-1:0] bit_we
  );
    return (old_data & ~bit_we) | (new_data & bit_we);
  endfunction

endpackage

// File: rtl/sram_lfsr32.sv
// Free-running 32-bit Galois LFSR, seedable, with its state replicated
// (or truncated) onto an output of arbitrary width.
//   clk    : clock, advances every posedge out of reset
//   rst_n  : asynchronous active-low reset, loads SEED
//   data_o : OUT_W bits, data_o[k] = state[k mod 32]
module sram_lfsr32
  import sram_model_pkg::*;
#(
  parameter int                OUT_W = 32,
  parameter logic [LFSR_W-1:0] SEED  = 32'hACE1_2024
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] data_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Right-shifting Galois form: the bit shifted out decides whether the
  // feedback mask is applied.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_MASK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar k = 0; k < OUT_W; k++) begin : g_rep
    assign data_o[k] = lfsr_q[k % LFSR_W];
  end

endmodule

// File: rtl/sram_sp_bw_model.sv
// Behavioural single-port synchronous SRAM with active-low controls,
// per-lane write mask, post-reset clear sequence and selectable Q policy.
//   CLK/RSTB : clock, asynchronous active-low reset
//   CEB/WEB  : chip enable / write enable (active-low); WEB=1 reads
//   BWEB     : per-lane write enable (active-low), lane i = bits [i*LW +: LW]
//   A/D      : word address / write data
//   Q        : registered read data (1-cycle latency)
//   READY    : clear sequence done, accesses accepted
//   ACC_DROP : pulse, access attempted before READY
//   OOR      : pulse, accepted access with A >= DEPTH
module sram_sp_bw_model
  import sram_model_pkg::*;
#(
  parameter int                BITS      = 64,
  parameter int                DEPTH     = 128,
  parameter int                ADDR_W    = 7,
  parameter int                LANES     = 8,
  parameter int                HOLD_Q    = 0,
  parameter logic [BITS-1:0]   INIT_VAL  = '0,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 32'hACE1_2024
) (
  input  logic              CLK,
  input  logic              RSTB,
  input  logic              CEB,
  input  logic              WEB,
  input  logic [LANES-1:0]  BWEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [BITS-1:0]   D,
  output logic [BITS-1:0]   Q,
  output logic              READY,
  output logic              ACC_DROP,
  output logic              OOR
);

  localparam int                LW       = BITS / LANES;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]   q_q, q_d;
  logic              ready_q, ready_d;
  logic              acc_drop_q, acc_drop_d;
  logic              oor_q, oor_d;

  logic [BITS-1:0]   ram [DEPTH];
  logic [BITS-1:0]   ram_rd;
  logic [BITS-1:0]   garbage;
  logic [BITS-1:0]   bit_we;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BITS-1:0]   mem_wdata;

  sram_lfsr32 #(
    .OUT_W (BITS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk    (CLK),
    .rst_n  (RSTB),
    .data_o (garbage)
  );

  // A full power-of-two array has no out-of-range addresses.
  if (DEPTH == (2 ** ADDR_W)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (A < ADDR_W'(DEPTH));
  end

  assign ram_rd = ram[A];

  always_comb begin
    bit_we = '0;
    for (int k = 0; k < BITS; k++) begin
      bit_we[k] = ~BWEB[k / LW];
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      q_q        <= '0;
      ready_q    <= 1'b0;
      acc_drop_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      ready_q    <= ready_d;
      acc_drop_q <= acc_drop_d;
      oor_q      <= oor_d;
    end
  end

  // Next-state logic
  // NOTE: every combinational output gets a default before any branch,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CLR_LAST) begin
        state_d = ST_RUN;
      end
    end
  end

  // Output / datapath logic
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = cnt_q;
    mem_wdata  = INIT_VAL;
    q_d        = (HOLD_Q != 0) ? q_q : garbage;
    ready_d    = (state_d == ST_RUN);
    acc_drop_d = 1'b0;
    oor_d      = 1'b0;
    if (state_q == ST_CLEAR) begin
      mem_we     = 1'b1;
      acc_drop_d = !CEB;
    end else if (!CEB) begin
      if (!in_range) begin
        oor_d = 1'b1;
        if (WEB) begin
          q_d = '0;
        end
      end else if (!WEB) begin
        mem_we    = 1'b1;
        mem_addr  = A;
        mem_wdata = BITS'(lane_merge(MERGE_MAX_W'(ram_rd), MERGE_MAX_W'(D),
                                     MERGE_MAX_W'(bit_we)));
      end else begin
        q_d = ram_rd;
      end
    end
  end

  // NOTE: the array has no reset; its contents are established by the
  // clear sequence, which keeps it mappable onto block RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end

  assign Q        = q_q;
  assign READY    = ready_q;
  assign ACC_DROP = acc_drop_q;
  assign OOR      = oor_q;

endmodule

// File: doc/sram_sp_bw_model.md
Name: sram_sp_bw_model

Overview:
- Parametrised behavioural model of a single-port synchronous SRAM macro with active-low controls.
- Adds per-lane write mask, a post-reset hardware clear sequence with READY handshake, and a selectable Q policy on non-read cycles: hold, or deterministic LFSR garbage.
- Out-of-range and dropped-access flags.
- Sits under the cache/TLB SRAM wrappers as the simulation and FPGA stand-in for all single-port macros, replacing fixed-size variants.

Parameters:
- BITS, 64, data width.
- DEPTH, 128, number of words; need not be a power of two.
- ADDR_W, 7, address width; must satisfy 2**ADDR_W >= DEPTH.
- LANES, 8, write-mask lanes; BITS must be divisible by LANES; lane width LW = BITS/LANES.
- HOLD_Q, 0, Q policy on non-read cycles: 1 = hold last value, 0 = drive LFSR garbage.
- INIT_VAL, 0, value written to every word by the clear sequence; width BITS.
- LFSR_SEED, 32'hACE1_2024, non-zero reset value of the garbage LFSR.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RSTB  in  1  asynchronous, active-low reset.
- CEB  in  1  chip enable, active-low.
- WEB  in  1  write enable, active-low; WEB=1 with CEB=0 is a read.
- BWEB  in  LANES  per-lane write enable, active-low; lane i covers D/ram bits [i*LW +: LW].
- A  in  ADDR_W  word address.
- D  in  BITS  write data.
- Q  out  BITS  registered read data.
- READY  out  1  high once the clear sequence is complete; accesses are accepted only while high.
- ACC_DROP  out  1  one-cycle pulse: access (CEB=0) attempted while READY=0.
- OOR  out  1  one-cycle pulse: accepted access with A >= DEPTH.

Behaviour:
- Reset (RSTB=0, asynchronous): Q=0, READY=0, ACC_DROP=0, OOR=0, FSM=CLEAR, clear counter=0, LFSR=LFSR_SEED. The memory array is not reset directly.
- FSM states:
  - CLEAR: each cycle writes INIT_VAL to ram[cnt] and increments cnt. When cnt==DEPTH-1 is written, go to RUN and set READY=1 on the same edge. CLEAR lasts exactly DEPTH cycles after the first posedge with RSTB=1.
  - RUN: terminal state; left only by reset.
  - Reset asserted mid-CLEAR restarts the sequence from word 0.
- During CLEAR:
  - CEB=0 is ignored: no write, no read; ACC_DROP=1 on the next edge.
  - Q follows the non-read policy.
- Write (RUN, CEB=0, WEB=0, A<DEPTH): for each lane i with BWEB[i]=0, ram[A] lane i <= D lane i; lanes with BWEB[i]=1 are unchanged.
  - BWEB all-ones: no change.
  - Q follows the non-read policy; no write-through.
- Read (RUN, CEB=0, WEB=1, A<DEPTH): Q <= ram[A] at the same edge, i.e. 1-cycle latency. BWEB and D are ignored.
- Out of range (RUN, CEB=0, A>=DEPTH):
  - Write is suppressed.
  - Read returns Q=0.
  - OOR=1 for one cycle.
- Non-read cycle (CEB=1, write, or CLEAR):
  - HOLD_Q=1: Q holds its previous value.
  - HOLD_Q=0: Q <= LFSR value replicated/truncated to BITS.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003.
  - Advances every cycle after reset, regardless of access.
  - Garbage mapping: Q bit k = lfsr[k mod 32].
- ACC_DROP and OOR are registered, high for exactly one cycle per offending access, and never high simultaneously.
- A read of an address written in the previous cycle returns the new data; there is no read-during-write hazard, since the port is single.

Decomposition:
- Package sram_model_pkg:
  - FSM state enum {CLEAR, RUN}.
  - LFSR width and mask constants.
  - Function for the lane-mask merge of old/new data.
- Sub-module sram_lfsr32: seedable free-running Galois LFSR with async active-low reset, output replicated to a parametrised width. It is shared with future two-port models.

Test Plan:
- Clear sequence, DEPTH=128: release RSTB, then hold CEB=1 → READY rises exactly 128 cycles later. Then read every address → Q=INIT_VAL (0) one cycle after each read.
- Masked write: write A=5, D=64'h1111_2222_3333_4444, BWEB=8'h00; then write A=5, D=64'hFFFF_FFFF_FFFF_FFFF, BWEB=8'hF0 → read A=5 gives 64'h1111_2222_FFFF_FFFF.
- Access during clear: CEB=0, WEB=0, A=3, D=all-ones at cycle 10 of CLEAR → ACC_DROP pulses one cycle. After READY, read A=3 → 0.
- Out of range, DEPTH=100, ADDR_W=7: write A=120 then read A=120 → OOR pulses on both accesses, and the read gives Q=0. ram[120 mod 100] is untouched, so read A=20 → INIT_VAL.
- Q policy: read A=5, then idle 3 cycles.
  - HOLD_Q=1 → Q stays at the A=5 data.
  - HOLD_Q=0 → Q equals the reference-model LFSR sequence from LFSR_SEED, matched cycle-exact.
- Reset mid-operation: assert RSTB during CLEAR at cnt=60 and again in RUN → Q, READY, flags and LFSR return to reset values asynchronously. CLEAR restarts at word 0 and READY returns DEPTH cycles after release.
